// File: rtl/pcs_deskew_ctrl_pkg.sv
// Shared XAUI receive-PCS definitions for the lane deskew controller:
// controller state encodings, the ||A|| code-group and the default skew budget.
package pcs_deskew_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEARCH  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_LOCKED  = 3'd4
    } deskew_state_t;

    // K28.3, the ||A|| alignment character
    localparam logic [7:0] K28_3 = 8'h7C;

    localparam int MAX_SKEW_DEF = 7;

endpackage

// File: rtl/pcs_deskew_lane_capture.sv
// Per-lane ||A|| arrival capture: byte-resolution timestamp, seen flag and
// a flag for a first arrival that lands beyond the skew window.
module pcs_deskew_lane_capture
    import pcs_deskew_ctrl_pkg::*;
#(
    parameter int DW = 4,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_lo,
    input  logic          i_hi,
    input  logic          i_capture,
    input  logic          i_clear,
    input  logic [CW-1:0] i_cnt,
    input  logic [DW:0]   i_limit,
    output logic          o_seen,
    output logic          o_new_hit,
    output logic          o_over,
    output logic [DW-1:0] o_arrival
);

    logic          r_seen;
    logic [DW-1:0] r_arrival;
    logic          w_off;
    logic [DW-1:0] w_arrival;

    // lo byte wins when both bytes of the cycle carry A; arrival = 2*cnt + offset
    assign w_off     = ~i_lo;
    assign w_arrival = DW'({i_cnt, w_off});

    assign o_new_hit = i_capture & (i_lo | i_hi) & ~r_seen;
    assign o_over    = o_new_hit & ({1'b0, w_arrival} > i_limit);
    assign o_seen    = r_seen;
    assign o_arrival = r_arrival;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen    <= 1'b0;
            r_arrival <= '0;
        end else if (i_clear) begin
            r_seen    <= 1'b0;
        end else if (o_new_hit) begin
            r_seen    <= 1'b1;
            r_arrival <= w_arrival;
        end
    end

endmodule

// File: rtl/pcs_deskew_ctrl.sv
// XAUI receive lane deskew controller: timestamps ||A|| on each of the four
// lanes, derives per-lane byte delays that align them, and holds them once locked.
module pcs_deskew_ctrl
    import pcs_deskew_ctrl_pkg::*;
#(
    parameter int MAX_SKEW = MAX_SKEW_DEF,
    parameter int DW       = 4,
    parameter int CW       = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_deskew,
    input  logic [3:0]      a_det_lo,
    input  logic [3:0]      a_det_hi,
    output logic [4*DW-1:0] lane_delay,
    output logic            delay_valid,
    output logic            deskew_busy,
    output logic            skew_fault,
    output logic [7:0]      fault_cnt
);

    deskew_state_t   r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_a_first;
    logic            r_en_d;
    logic [4*DW-1:0] r_lane_delay;
    logic            r_delay_valid;
    logic            r_skew_fault;
    logic [7:0]      r_fault_cnt;

    logic [3:0]      w_seen;
    logic [3:0]      w_new_hit;
    logic [3:0]      w_over;
    logic [DW-1:0]   w_arr [4];
    logic [3:0]      w_seen_next;
    logic [DW:0]     w_limit;
    logic            w_active;
    logic            w_capture;
    logic            w_expire;
    logic            w_fault;
    logic            w_clear;
    logic [DW-1:0]   w_max;
    logic [4*DW-1:0] w_delay;

    assign w_active    = (r_state == ST_SEARCH) || (r_state == ST_COLLECT);
    assign w_capture   = w_active && enable_deskew;
    assign w_seen_next = w_seen | w_new_hit;
    assign w_limit     = (DW+1)'(r_a_first) + (DW+1)'(MAX_SKEW);

    // window has closed once the earliest byte this cycle lies past a_first+MAX_SKEW
    assign w_expire = ((DW+1)'({r_cnt, 1'b0}) > w_limit) && (w_seen_next != 4'hF);
    assign w_fault  = (r_state == ST_COLLECT) && enable_deskew && ((|w_over) || w_expire);
    assign w_clear  = !w_active || w_fault;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        pcs_deskew_lane_capture #(
            .DW (DW),
            .CW (CW)
        ) u_cap (
            .clk       (clk),
            .reset     (reset),
            .i_lo      (a_det_lo[g]),
            .i_hi      (a_det_hi[g]),
            .i_capture (w_capture),
            .i_clear   (w_clear),
            .i_cnt     (r_cnt),
            .i_limit   (w_limit),
            .o_seen    (w_seen[g]),
            .o_new_hit (w_new_hit[g]),
            .o_over    (w_over[g]),
            .o_arrival (w_arr[g])
        );
    end

    always_comb begin
        w_max   = '0;
        w_delay = '0;
        for (int i = 0; i < 4; i++)
            if (w_arr[i] > w_max) w_max = w_arr[i];
        for (int i = 0; i < 4; i++)
            w_delay[DW*i +: DW] = w_max - w_arr[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_a_first     <= 1'b0;
            r_en_d        <= 1'b0;
            r_lane_delay  <= '0;
            r_delay_valid <= 1'b0;
            r_skew_fault  <= 1'b0;
            r_fault_cnt   <= '0;
        end else begin
            r_en_d       <= enable_deskew;
            r_skew_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable_deskew) begin
                        r_state <= ST_SEARCH;
                        r_cnt   <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (!enable_deskew) begin
                        r_state <= ST_IDLE;
                    end else if (|w_new_hit) begin
                        r_a_first <= ~(|a_det_lo);
                        if (w_seen_next == 4'hF) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_state <= ST_COLLECT;
                            r_cnt   <= CW'(1);
                        end
                    end
                end
                ST_COLLECT: begin
                    if (!enable_deskew) begin
                        r_state <= ST_IDLE;
                    end else if (w_fault) begin
                        r_state      <= ST_SEARCH;
                        r_cnt        <= '0;
                        r_skew_fault <= 1'b1;
                        if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
                    end else if (w_seen_next == 4'hF) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_COMMIT: begin
                    r_lane_delay  <= w_delay;
                    r_delay_valid <= 1'b1;
                    r_state       <= ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (enable_deskew && !r_en_d) begin
                        r_state       <= ST_SEARCH;
                        r_cnt         <= '0;
                        r_delay_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign deskew_busy = w_active || (r_state == ST_COMMIT);
    assign lane_delay  = r_lane_delay;
    assign delay_valid = r_delay_valid;
    assign skew_fault  = r_skew_fault;
    assign fault_cnt   = r_fault_cnt;

endmodule

// File: tb/tb_pcs_deskew_ctrl.sv
// Directed bench for pcs_deskew_ctrl: hand-computed lane delays, window
// faults, fault counter saturation, abort and reset behaviour.
module tb_pcs_deskew_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_deskew;
    logic [3:0]  a_det_lo;
    logic [3:0]  a_det_hi;
    logic [15:0] lane_delay;
    logic        delay_valid;
    logic        deskew_busy;
    logic        skew_fault;
    logic [7:0]  fault_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pcs_deskew_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .enable_deskew (enable_deskew),
        .a_det_lo      (a_det_lo),
        .a_det_hi      (a_det_hi),
        .lane_delay    (lane_delay),
        .delay_valid   (delay_valid),
        .deskew_busy   (deskew_busy),
        .skew_fault    (skew_fault),
        .fault_cnt     (fault_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one cycle of A detections, then return to idle lines
    task automatic apply(input logic [3:0] lo, input logic [3:0] hi);
        a_det_lo = lo;
        a_det_hi = hi;
        tick();
        a_det_lo = 4'h0;
        a_det_hi = 4'h0;
    endtask

    task automatic rearm();
        enable_deskew = 1'b0;
        tick();
        enable_deskew = 1'b1;
        tick();
    endtask

    // arrivals 0,1,2(,lane2 hi optional),5 -> delays {0,3,4,5}
    task automatic skew_pattern(input logic lane2_hi);
        apply(4'b0001, 4'b0010);
        apply(4'b0100, {1'b0, lane2_hi, 2'b00});
        apply(4'b0000, 4'b1000);
        tick();
    endtask

    // lanes 0-2 at c0, lane3 absent until the window closes at c4
    task automatic missing_lane3();
        apply(4'b0111, 4'b0000);
        repeat (4) tick();
    endtask

    initial begin
        reset         = 1'b1;
        enable_deskew = 1'b0;
        a_det_lo      = 4'h0;
        a_det_hi      = 4'h0;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_delay", lane_delay, 16'h0000);
        chk("rst_valid", delay_valid, 1'b0);
        chk("rst_busy", deskew_busy, 1'b0);
        chk("rst_fault", skew_fault, 1'b0);
        chk("rst_fcnt", fault_cnt, 8'd0);

        // all lanes aligned
        enable_deskew = 1'b1;
        tick();
        chk("search_busy", deskew_busy, 1'b1);
        apply(4'b1111, 4'b0000);
        chk("commit_valid_early", delay_valid, 1'b0);
        tick();
        chk("aligned_delay", lane_delay, 16'h0000);
        chk("aligned_valid", delay_valid, 1'b1);
        chk("aligned_fcnt", fault_cnt, 8'd0);
        chk("locked_busy", deskew_busy, 1'b0);

        // staggered arrivals 0,1,2,5
        rearm();
        chk("rearm_valid", delay_valid, 1'b0);
        skew_pattern(1'b0);
        chk("skew_delay", lane_delay, 16'h0345);
        chk("skew_valid", delay_valid, 1'b1);

        // window expiry with lane3 missing
        rearm();
        apply(4'b0111, 4'b0000);
        repeat (3) tick();
        chk("pre_expire_fault", skew_fault, 1'b0);
        tick();
        chk("expire_fault", skew_fault, 1'b1);
        chk("expire_fcnt", fault_cnt, 8'd1);
        chk("expire_busy", deskew_busy, 1'b1);
        chk("expire_valid", delay_valid, 1'b0);
        chk("expire_delay", lane_delay, 16'h0345);
        tick();
        chk("fault_pulse", skew_fault, 1'b0);

        // saturation after 300 faults total
        for (int i = 0; i < 299; i++) missing_lane3();
        chk("sat_fault", skew_fault, 1'b1);
        chk("sat_fcnt", fault_cnt, 8'd255);

        // late arrival at byte 8 is a fault, not a commit
        tick();
        apply(4'b0111, 4'b0000);
        repeat (3) tick();
        apply(4'b1000, 4'b0000);
        chk("late_fault", skew_fault, 1'b1);
        tick();
        tick();
        chk("late_no_commit", delay_valid, 1'b0);
        chk("late_delay", lane_delay, 16'h0345);

        // arrival at byte 7 is the last one inside the window
        apply(4'b0111, 4'b0000);
        repeat (2) tick();
        apply(4'b0000, 4'b1000);
        chk("edge_no_fault", skew_fault, 1'b0);
        tick();
        chk("edge_delay", lane_delay, 16'h0777);
        chk("edge_valid", delay_valid, 1'b1);

        // relock to {5,4,3,0}, then abort a new search mid-collect
        rearm();
        skew_pattern(1'b0);
        chk("relock_delay", lane_delay, 16'h0345);
        rearm();
        apply(4'b0011, 4'b0000);
        enable_deskew = 1'b0;
        tick();
        chk("abort_busy", deskew_busy, 1'b0);
        chk("abort_delay", lane_delay, 16'h0345);
        chk("abort_fault", skew_fault, 1'b0);
        chk("abort_valid", delay_valid, 1'b0);

        // reset in the middle of COLLECT
        enable_deskew = 1'b1;
        tick();
        apply(4'b0001, 4'b0000);
        chk("collect_busy", deskew_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_delay", lane_delay, 16'h0000);
        chk("mid_rst_valid", delay_valid, 1'b0);
        chk("mid_rst_busy", deskew_busy, 1'b0);
        chk("mid_rst_fcnt", fault_cnt, 8'd0);

        // lane2 with both bytes set: lo wins, arrival 2
        tick();
        skew_pattern(1'b1);
        chk("lo_wins_delay", lane_delay, 16'h0345);
        chk("lo_wins_valid", delay_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
